// File: rtl/sparse_expand_if.sv
// Handshake bundle for sparse_expand: compressed-entry input side, dense-element
// output side and the sticky error flag.
interface sparse_expand_if #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [IDX_W-1:0]  in_idx;
   logic              in_last;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;
   logic              err;
   logic              err_clr;

   modport slave (
      input  in_valid, in_data, in_idx, in_last, out_ready, err_clr,
      output in_ready, out_valid, out_data, out_last, err
   );

   modport master (
      output in_valid, in_data, in_idx, in_last, out_ready, err_clr,
      input  in_ready, out_valid, out_data, out_last, err
   );
endinterface

// File: rtl/sparse_expand.sv
// Expands (value, position, last) sparse entries into dense groups of 2^IDX_W
// elements, zero-filling gaps and the tail, and flags ordering violations.
module sparse_expand #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
) (
   input  logic           clk,
   input  logic           rst,
   sparse_expand_if.slave bus
);
   typedef enum logic {ST_EXPAND, ST_FILL} state_t;

   localparam logic [IDX_W-1:0] POS_MAX = '1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  pos_q, pos_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              err_q, err_d;
   logic              load, hit, behind, in_ready;

   assign load   = !out_valid_q || bus.out_ready;
   assign hit    = (bus.in_idx == pos_q);
   assign behind = (bus.in_idx < pos_q);

   // An entry behind pos is taken (and dropped) so the stream cannot deadlock.
   assign in_ready = !rst && load && (state_q == ST_EXPAND) && bus.in_valid && (hit || behind);

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      err_d       = err_q && !bus.err_clr;
      if (load) begin
         out_valid_d = 1'b0;
         case (state_q)
            ST_EXPAND: begin
               if (bus.in_valid) begin
                  if (behind) begin
                     err_d = 1'b1;
                     if (bus.in_last && (pos_q != '0)) state_d = ST_FILL;
                  end else begin
                     out_valid_d = 1'b1;
                     out_data_d  = hit ? bus.in_data : '0;
                     out_last_d  = (pos_q == POS_MAX);
                     pos_d       = pos_q + 1'b1;
                     if (hit && bus.in_last && (pos_q != POS_MAX)) state_d = ST_FILL;
                     if ((pos_q == POS_MAX) && !bus.in_last) err_d = 1'b1;
                  end
               end
            end
            ST_FILL: begin
               out_valid_d = 1'b1;
               out_data_d  = '0;
               out_last_d  = (pos_q == POS_MAX);
               pos_d       = pos_q + 1'b1;
               if (pos_q == POS_MAX) state_d = ST_EXPAND;
            end
            default: state_d = ST_EXPAND;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EXPAND;
         pos_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_sparse_expand.sv
// Bench for sparse_expand: directed group table, reset/backpressure sequences
// and random well-formed groups checked against a dense-array model.
module tb_sparse_expand;
   typedef struct packed {
      logic [4:0]        n;
      logic [15:0][7:0]  d;
      logic [15:0][3:0]  ix;
      logic [15:0]       l;
      logic [15:0][7:0]  ev;
      logic [4:0]        eacc;
      logic              eerr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;
   int   rdy_mode = 0;
   int   acc_cnt  = 0;
   logic [7:0] outq_d[$];
   logic       outq_l[$];
   int         outq_c[$];
   logic       stall_pend = 1'b0;
   logic [7:0] held_d;
   logic       held_l;

   sparse_expand_if #(.DATA_W(8), .IDX_W(4)) bus ();
   sparse_expand #(.DATA_W(8), .IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (rdy_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = (cyc % 3 == 0);
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_data", int'(bus.out_data), int'(held_d));
            chk("stall_last", int'(bus.out_last), int'(held_l));
         end
         stall_pend = bus.out_valid && !bus.out_ready;
         held_d = bus.out_data;
         held_l = bus.out_last;
         if (bus.out_valid && bus.out_ready) begin
            outq_d.push_back(bus.out_data);
            outq_l.push_back(bus.out_last);
            outq_c.push_back(cyc);
         end
         if (bus.in_valid && bus.in_ready) acc_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_entry(input logic [7:0] d, input logic [3:0] ix, input logic l, output bit ok);
      bit acc;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_idx   = ix;
      bus.in_last  = l;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
         ok = acc;
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("entry_accept_timeout", 0, 1);
   endtask

   function automatic vec_t add(input vec_t v, input int d, input int ix, input bit l);
      vec_t r = v;
      r.d[v.n]  = 8'(d);
      r.ix[v.n] = 4'(ix);
      r.l[v.n]  = l;
      r.n       = v.n + 5'd1;
      return r;
   endfunction

   task automatic run_group(input vec_t v, input int gap_max, input string name, input bit contig);
      bit ok;
      outq_d.delete(); outq_l.delete(); outq_c.delete();
      acc_cnt = 0;
      for (int i = 0; i < int'(v.n); i++) begin
         repeat ($urandom_range(0, gap_max)) step();
         drive_entry(v.d[i], v.ix[i], v.l[i], ok);
      end
      for (int t = 0; t < 300 && outq_d.size() < 16; t++) step();
      repeat (3) step();
      chk({name, " out_count"}, outq_d.size(), 16);
      for (int j = 0; j < 16 && j < outq_d.size(); j++) begin
         chk($sformatf("%s data[%0d]", name, j), int'(outq_d[j]), int'(v.ev[j]));
         chk($sformatf("%s last[%0d]", name, j), int'(outq_l[j]), (j == 15) ? 1 : 0);
      end
      if (contig && outq_c.size() == 16) chk({name, " no_bubbles"}, outq_c[15] - outq_c[0], 15);
      chk({name, " accepts"}, acc_cnt, int'(v.eacc));
      chk({name, " err"}, int'(bus.err), int'(v.eerr));
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      chk({name, " err_cleared"}, int'(bus.err), 0);
   endtask

   vec_t tbl[6];
   vec_t v;

   initial begin
      bit ok;
      int mask;
      bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.in_idx = 4'd0; bus.in_last = 1'b0;
      bus.err_clr = 1'b0; bus.out_ready = 1'b1;

      for (int k = 0; k < 6; k++) tbl[k] = '0;
      tbl[0] = add(add(tbl[0], 5, 2, 0), 7, 9, 1);
      tbl[0].ev[2] = 8'd5; tbl[0].ev[9] = 8'd7; tbl[0].eacc = 5'd2;
      tbl[1] = add(tbl[1], 0, 0, 1);
      tbl[1].eacc = 5'd1;
      tbl[2] = add(add(add(tbl[2], 3, 4, 0), 8, 2, 0), 9, 6, 1);
      tbl[2].ev[4] = 8'd3; tbl[2].ev[6] = 8'd9; tbl[2].eacc = 5'd3; tbl[2].eerr = 1'b1;
      tbl[3] = add(tbl[3], 8'h42, 15, 1);
      tbl[3].ev[15] = 8'h42; tbl[3].eacc = 5'd1;
      tbl[4] = add(add(tbl[4], 1, 3, 0), 2, 1, 1);
      tbl[4].ev[3] = 8'd1; tbl[4].eacc = 5'd2; tbl[4].eerr = 1'b1;
      tbl[5] = add(add(tbl[5], 8'hAA, 0, 0), 8'hBB, 1, 1);
      tbl[5].ev[0] = 8'hAA; tbl[5].ev[1] = 8'hBB; tbl[5].eacc = 5'd2;

      // reset state, with a pending entry that must not be accepted
      #3;
      chk("rst out_valid", int'(bus.out_valid), 0);
      chk("rst out_data", int'(bus.out_data), 0);
      chk("rst out_last", int'(bus.out_last), 0);
      chk("rst err", int'(bus.err), 0);
      chk("rst in_ready", int'(bus.in_ready), 0);
      step(); step();
      chk("rst held out_valid", int'(bus.out_valid), 0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      step();

      for (int k = 0; k < 6; k++) run_group(tbl[k], 0, $sformatf("vec%0d", k), 1'b0);

      rdy_mode = 1;
      run_group(tbl[0], 0, "backpressure", 1'b0);
      rdy_mode = 0;

      v = '0;
      for (int k = 0; k < 16; k++) begin
         v = add(v, k + 1, k, k == 15);
         v.ev[k] = 8'(k + 1);
      end
      v.eacc = 5'd16;
      run_group(v, 0, "dense", 1'b1);

      v.l = '0;
      v.eerr = 1'b1;
      run_group(v, 0, "missing_last", 1'b0);
      run_group(tbl[0], 0, "after_missing", 1'b0);

      // mid-group reset after five outputs
      outq_d.delete(); outq_l.delete(); outq_c.delete();
      drive_entry(8'd5, 4'd2, 1'b0, ok);
      bus.in_valid = 1'b1; bus.in_data = 8'd7; bus.in_idx = 4'd9; bus.in_last = 1'b1;
      for (int t = 0; t < 50 && outq_d.size() < 5; t++) step();
      chk("midrst reached5", int'(outq_d.size() >= 5), 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst out_valid", int'(bus.out_valid), 0);
      chk("midrst out_data", int'(bus.out_data), 0);
      chk("midrst out_last", int'(bus.out_last), 0);
      chk("midrst in_ready", int'(bus.in_ready), 0);
      step();
      bus.in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      run_group(tbl[0], 0, "after_rst", 1'b0);

      // random well-formed groups under random gaps and backpressure
      rdy_mode = 2;
      for (int g = 0; g < 25; g++) begin
         v = '0;
         mask = (g % 5 == 4) ? 32'hFFFF : int'($urandom & $urandom & 32'hFFFF);
         if (mask == 0) mask = 1 << $urandom_range(0, 15);
         for (int p = 0; p < 16; p++) begin
            if (mask[p]) begin
               v = add(v, $urandom_range(0, 255), p, 1'b0);
               v.ev[p] = v.d[v.n - 1];
            end
         end
         v.l[v.n - 1] = 1'b1;
         v.eacc = v.n;
         run_group(v, 2, $sformatf("rand%0d", g), 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
